// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Optional JAL support is enabled by defining MULTI_CTRL_JAL_EN.
package mips_mc_pkg;

   // 4-bit state encoding; IDLE must stay 0 so state_o reads 0 out of reset.
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_RTEXEC   = 4'd7,
      S_RTWB     = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_HALT     = 4'd13
`ifdef MULTI_CTRL_JAL_EN
      ,
      S_JAL      = 4'd14
`endif
   } state_t;

   // ALU operation class handed to the ALU decoder.
   // AOP_NONE drives alu_ctrl to 000 in states that do not use the ALU.
   typedef enum logic [1:0] {
      AOP_ADD   = 2'd0,
      AOP_SUB   = 2'd1,
      AOP_FUNCT = 2'd2,
      AOP_NONE  = 2'd3
   } aluop_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_OFF = 3'b000;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_4     = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // States that wait on the memory handshake and feed the timeout counter.
   function automatic logic is_wait(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder: maps an ALU-op class and funct to alu_ctrl.
// Ports: alu_op (class in), funct (IR[5:0] in), alu_ctrl (3-bit ALU op out).
module mips_alu_decoder
   import mips_mc_pkg::*;
(
   input  aluop_t     alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_OFF;
      case (alu_op)
         AOP_ADD: alu_ctrl = ALU_ADD;
         AOP_SUB: alu_ctrl = ALU_SUB;
         AOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_OFF;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with memory-ready timeout.
// Ports: clk, reset (async high), op/funct/zero/mem_ready in; datapath
// enables and selects, halted and state_o out. Macro: MULTI_CTRL_JAL_EN.
module mips_multicycle_ctrl
   import mips_mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       halted,
   output logic [3:0] state_o
);

   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

   state_t        state;
   state_t        state_n;
   aluop_t        alu_op;
   logic [CW-1:0] cnt;
   logic          timeout;

   assign timeout = (cnt == LIM) && !mem_ready;
   assign state_o = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Counts stalled cycles of the current wait state; any state change clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state_n != state) begin
         cnt <= '0;
      end else if (is_wait(state) && !mem_ready) begin
         cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_n    = state;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = RD_RT;
      mem_to_reg = M2R_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = AOP_NONE;
      pc_src     = PCSRC_ALU;
      pc_en      = 1'b0;
      halted     = 1'b0;
      case (state)
         S_IDLE: state_n = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_4;
            alu_op    = AOP_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_n  = S_DECODE;
            end else if (timeout) begin
               state_n = S_HALT;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMMSH;
            alu_op    = AOP_ADD;
            case (op)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_R:         state_n = S_RTEXEC;
               OP_ADDI:      state_n = S_ADDIEXEC;
               OP_BEQ:       state_n = S_BRANCH;
               OP_J:         state_n = S_JUMP;
`ifdef MULTI_CTRL_JAL_EN
               OP_JAL:       state_n = S_JAL;
`endif
               default:      state_n = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = AOP_ADD;
            state_n   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_n = S_MEMWB;
            else if (timeout) state_n = S_HALT;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            reg_dst    = RD_RT;
            mem_to_reg = M2R_MDR;
            state_n    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_n = S_FETCH;
            else if (timeout) state_n = S_HALT;
         end
         S_RTEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = AOP_FUNCT;
            state_n   = S_RTWB;
         end
         S_RTWB: begin
            reg_write  = 1'b1;
            reg_dst    = RD_RD;
            mem_to_reg = M2R_ALUOUT;
            state_n    = S_FETCH;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = AOP_ADD;
            state_n   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            reg_dst    = RD_RT;
            mem_to_reg = M2R_ALUOUT;
            state_n    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = AOP_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_en     = zero;
            state_n   = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PCSRC_JUMP;
            pc_en   = 1'b1;
            state_n = S_FETCH;
         end
`ifdef MULTI_CTRL_JAL_EN
         // PC already holds PC+4 from FETCH, so $31 gets the return address.
         S_JAL: begin
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = M2R_PC;
            pc_src     = PCSRC_JUMP;
            pc_en      = 1'b1;
            state_n    = S_FETCH;
         end
`endif
         S_HALT: halted = 1'b1;
         default: state_n = S_HALT;
      endcase
   end

   mips_alu_decoder u_alu_dec (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctrl (alu_ctrl)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed plus random
// instruction streams with memory stalls, checked against a phase model.
module tb_mips_multicycle_ctrl;
   import mips_mc_pkg::*;

   localparam int WL = 15;
   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_JAL  = 6'b000011;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       halted;
      logic [3:0] state;
   } ctl_t;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       iord, mem_read, mem_write, ir_write, reg_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
   logic       alu_src_a, pc_en, halted;
   logic [2:0] alu_ctrl;
   logic [3:0] state_o;

   int tests = 0;
   int fails = 0;

   mips_multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .halted     (halted),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] fmap(logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected control word for a state, straight from the state output table.
   function automatic ctl_t model(state_t s, logic [5:0] f, logic z, logic r);
      ctl_t c;
      c = '0;
      c.state = s;
      case (s)
         S_FETCH: begin
            c.mem_read = 1; c.alu_src_b = 1; c.alu_ctrl = 3'b010;
            c.ir_write = r; c.pc_en = r;
         end
         S_DECODE: begin c.alu_src_b = 3; c.alu_ctrl = 3'b010; end
         S_MEMADR: begin
            c.alu_src_a = 1; c.alu_src_b = 2; c.alu_ctrl = 3'b010;
         end
         S_MEMRD: begin c.iord = 1; c.mem_read = 1; end
         S_MEMWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
         S_MEMWR: begin c.iord = 1; c.mem_write = 1; end
         S_RTEXEC: begin c.alu_src_a = 1; c.alu_ctrl = fmap(f); end
         S_RTWB: begin c.reg_write = 1; c.reg_dst = 1; end
         S_ADDIEXEC: begin
            c.alu_src_a = 1; c.alu_src_b = 2; c.alu_ctrl = 3'b010;
         end
         S_ADDIWB: c.reg_write = 1;
         S_BRANCH: begin
            c.alu_src_a = 1; c.alu_ctrl = 3'b110;
            c.pc_src = 1; c.pc_en = z;
         end
         S_JUMP: begin c.pc_src = 2; c.pc_en = 1; end
`ifdef MULTI_CTRL_JAL_EN
         S_JAL: begin
            c.reg_write = 1; c.reg_dst = 2; c.mem_to_reg = 2;
            c.pc_src = 2; c.pc_en = 1;
         end
`endif
         S_HALT: c.halted = 1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctl_t snap();
      return {iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
              mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en,
              halted, state_o};
   endfunction

   task automatic check(input string tag, input ctl_t act, input ctl_t exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step(input state_t s, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic r);
      op = o; funct = f; zero = z; mem_ready = r;
      #1;
      check(s.name(), snap(), model(s, f, z, r));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      #1;
      check("reset", snap(), model(S_IDLE, 6'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(S_IDLE, 6'd0, 6'd0, 1'b0, 1'($urandom));
   endtask

   task automatic sit_halt(input logic [5:0] o, input logic [5:0] f);
      repeat (3) step(S_HALT, o, f, 1'($urandom), 1'($urandom));
      do_reset();
   endtask

   // Runs one instruction from FETCH; fs/ms are stall cycles in the fetch
   // and data-memory waits, and a count above WL models a dead memory.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fs, input int ms);
      state_t ph[$];
      int n;
      ph.push_back(S_FETCH);
      ph.push_back(S_DECODE);
      case (o)
         T_LW: begin
            ph.push_back(S_MEMADR); ph.push_back(S_MEMRD);
            ph.push_back(S_MEMWB);
         end
         T_SW: begin ph.push_back(S_MEMADR); ph.push_back(S_MEMWR); end
         T_R: begin ph.push_back(S_RTEXEC); ph.push_back(S_RTWB); end
         T_ADDI: begin
            ph.push_back(S_ADDIEXEC); ph.push_back(S_ADDIWB);
         end
         T_BEQ: ph.push_back(S_BRANCH);
         T_J: ph.push_back(S_JUMP);
`ifdef MULTI_CTRL_JAL_EN
         T_JAL: ph.push_back(S_JAL);
`endif
         default: ph.push_back(S_HALT);
      endcase
      foreach (ph[i]) begin
         if (ph[i] == S_FETCH || ph[i] == S_MEMRD || ph[i] == S_MEMWR) begin
            n = (ph[i] == S_FETCH) ? fs : ms;
            if (n > WL) begin
               repeat (WL + 1) step(ph[i], o, f, z, 1'b0);
               sit_halt(o, f);
               return;
            end
            repeat (n) step(ph[i], o, f, z, 1'b0);
            step(ph[i], o, f, z, 1'b1);
         end else if (ph[i] == S_HALT) begin
            sit_halt(o, f);
            return;
         end else begin
            step(ph[i], o, f, z, 1'($urandom));
         end
      end
   endtask

   logic [5:0] fl [5];
   logic [5:0] ro, rf;
   int         pick;

   initial begin
      fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
      fl[3] = 6'b100101; fl[4] = 6'b101010;
      reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      #2;
      do_reset();

      run_instr(T_LW, 6'd0, 1'b0, 0, 0);
      run_instr(T_R, 6'b100000, 1'b0, 0, 0);
      run_instr(T_BEQ, 6'd0, 1'b1, 0, 0);
      run_instr(T_BEQ, 6'd0, 1'b0, 0, 0);
      run_instr(T_SW, 6'd0, 1'b0, 0, 3);
      run_instr(T_ADDI, 6'd0, 1'b0, 0, 0);
      run_instr(T_J, 6'd0, 1'b0, 0, 0);
      for (int i = 1; i < 5; i++) run_instr(T_R, fl[i], 1'b0, 0, 0);
      run_instr(T_R, 6'b000111, 1'b0, 0, 0);
      run_instr(T_LW, 6'd0, 1'b0, WL, WL);
      run_instr(T_SW, 6'd0, 1'b0, WL, WL);
      run_instr(T_R, 6'b100000, 1'b0, WL + 1, 0);
      run_instr(T_LW, 6'd0, 1'b0, 0, WL + 1);
      run_instr(T_SW, 6'd0, 1'b0, 2, WL + 1);
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
      run_instr(T_JAL, 6'd0, 1'b0, 0, 0);

      step(S_FETCH, T_LW, 6'd0, 1'b0, 1'b1);
      step(S_DECODE, T_LW, 6'd0, 1'b0, 1'b1);
      step(S_MEMADR, T_LW, 6'd0, 1'b0, 1'b1);
      mem_ready = 1'b0;
      #1;
      check("memrd_pre", snap(), model(S_MEMRD, 6'd0, 1'b0, 1'b0));
      reset = 1'b1;
      #1;
      check("reset_mid", snap(), model(S_IDLE, 6'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(S_IDLE, T_LW, 6'd0, 1'b0, 1'b1);
      run_instr(T_R, 6'b100010, 1'b0, 0, 0);

      for (int k = 0; k < 80; k++) begin
         pick = $urandom_range(0, 9);
         rf = fl[$urandom_range(0, 4)];
         case (pick)
            0: ro = T_LW;
            1: ro = T_SW;
            2, 3: ro = T_R;
            4: ro = T_ADDI;
            5: ro = T_BEQ;
            6: ro = T_J;
            7: ro = T_JAL;
            8: ro = {2'b11, 4'($urandom)};
            default: begin ro = T_R; rf = 6'($urandom); end
         endcase
         run_instr(ro, rf, 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
